rtc_frame_fetch: RTL

- Schedules the periodic read of the nine RTC time, date and timer registers over the shared RTC register bus.
- Sequences the reads once every FRAME_DIV vertical-blanking starts and holds the values in shadow registers.
- Drives the display path's DIA_T…SEGUNDOT_T inputs. All nine values update atomically in one cycle, so a frame never shows mixed old and new digits.
- Yields the bus to pending user writes, and aborts with an error flag if the RTC side stops acknowledging.

---
 rtl/rtc_frame_fetch.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rtc_frame_fetch.sv
// Periodic nine-register RTC fetch into shadow registers, committed atomically
// once every FRAME_DIV frame starts; yields to user writes, aborts on bus timeout.
//
//   state  | meaning
//   IDLE   | waiting for a divided frame-start trigger
//   HOLD   | bus released (gap between reads, or yielding to a user write)
//   REQ    | read of register idx outstanding, timeout running
//   COMMIT | staged values copied to shadows, one-cycle done pulse
module rtc_frame_fetch #(
  parameter int FRAME_DIV   = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       frame_start_i,
  input  logic       wr_pend_i,
  output logic       bus_req_o,
  output logic [7:0] bus_addr_o,
  input  logic       bus_ack_i,
  input  logic [7:0] bus_rdata_i,
  output logic [7:0] dia_t_o,
  output logic [7:0] mes_t_o,
  output logic [7:0] ano_t_o,
  output logic [7:0] hora_t_o,
  output logic [7:0] minuto_t_o,
  output logic [7:0] segundo_t_o,
  output logic [7:0] horat_t_o,
  output logic [7:0] minutot_t_o,
  output logic [7:0] segundot_t_o,
  output logic       busy_o,
  output logic       update_done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_REQ, S_COMMIT} state_t;

  localparam logic [3:0] DIV_LAST = 4'(FRAME_DIV - 1);
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] LAST_IDX = 4'd8;

  function automatic logic [7:0] reg_addr(input logic [3:0] idx);
    case (idx)
      4'd0:    reg_addr = 8'h24;
      4'd1:    reg_addr = 8'h25;
      4'd2:    reg_addr = 8'h26;
      4'd3:    reg_addr = 8'h23;
      4'd4:    reg_addr = 8'h22;
      4'd5:    reg_addr = 8'h21;
      4'd6:    reg_addr = 8'h43;
      4'd7:    reg_addr = 8'h42;
      4'd8:    reg_addr = 8'h41;
      default: reg_addr = 8'h00;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      div_q, div_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      tmo_q, tmo_d;
  logic [7:0]      addr_q, addr_d;
  logic            err_q, err_d;
  logic [8:0][7:0] stage_q, stage_d;
  logic [8:0][7:0] shadow_q, shadow_d;
  logic            trigger;

  assign trigger = frame_start_i && (div_q == DIV_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      idx_q    <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      stage_q  <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      stage_q  <= stage_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    idx_d    = idx_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    err_d    = err_q;
    stage_d  = stage_q;
    shadow_d = shadow_q;

    // The divider runs in every state so trigger phase is independent of fetch length.
    if (frame_start_i) div_d = trigger ? 4'd0 : div_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          state_d = S_HOLD;
          idx_d   = '0;
        end
      end
      S_HOLD: begin
        if (!wr_pend_i) begin
          state_d = S_REQ;
          addr_d  = reg_addr(idx_q);
          tmo_d   = TMO_LOAD;
        end
      end
      S_REQ: begin
        if (bus_ack_i) begin
          stage_d[idx_q] = bus_rdata_i;
          if (idx_q == LAST_IDX) begin
            // Last byte goes straight into the shadows on the same edge it is captured.
            state_d  = S_COMMIT;
            shadow_d = stage_d;
            err_d    = 1'b0;
          end else begin
            state_d = S_HOLD;
            idx_d   = idx_q + 4'd1;
          end
        end else if (tmo_q == 8'd0) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          stage_d = '0;
        end else begin
          tmo_d = tmo_q - 8'd1;
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign bus_req_o     = (state_q == S_REQ);
  assign bus_addr_o    = addr_q;
  assign busy_o        = (state_q != S_IDLE);
  assign update_done_o = (state_q == S_COMMIT);
  assign err_o         = err_q;

  assign dia_t_o      = shadow_q[0];
  assign mes_t_o      = shadow_q[1];
  assign ano_t_o      = shadow_q[2];
  assign hora_t_o     = shadow_q[3];
  assign minuto_t_o   = shadow_q[4];
  assign segundo_t_o  = shadow_q[5];
  assign horat_t_o    = shadow_q[6];
  assign minutot_t_o  = shadow_q[7];
  assign segundot_t_o = shadow_q[8];

endmodule
